// File: rtl/player_move_ctrl.sv
// Player cannon sequencer: rate-limited, clamped joystick motion plus a single-outstanding shot FSM.
// Optional: define PLAYER_ACCEL_EN for double step after a sustained same-direction hold.
module player_move_ctrl #(
    parameter int unsigned TICK_DIV       = 250000,
    parameter int unsigned STEP           = 5,
    parameter int unsigned COL_MIN        = 5,
    parameter int unsigned COL_MAX        = 635,
    parameter int unsigned COL_INIT       = 310,
    parameter int unsigned ROW_INIT       = 350,
    parameter int unsigned COOLDOWN_TICKS = 8
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic [3:0] Joystick_data,
    input  logic       Fire_btn,
    input  logic       Shot_busy,
    input  logic       Shot_ack,
    output logic       Shot_req,
    output logic [9:0] Shot_col,
    output logic [8:0] Player_Row,
    output logic [9:0] Player_Col,
    output logic       Move_tick
);

    localparam int unsigned TW  = $clog2(TICK_DIV);
    localparam int unsigned CDW = $clog2(COOLDOWN_TICKS + 1);

    localparam logic [TW-1:0]       TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [CDW-1:0]      CD_LOAD   = CDW'(COOLDOWN_TICKS);
    localparam logic signed [10:0]  MIN_S     = 11'(COL_MIN);
    localparam logic signed [10:0]  MAX_S     = 11'(COL_MAX);
    localparam logic signed [10:0]  STEP_S    = 11'(STEP);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_COOL} state_t;

    logic [TW-1:0]      tick_cnt;
    logic [3:0]         joy_q;
    logic               go_right, go_left;
    logic signed [10:0] step_s;
    logic signed [10:0] col_s, col_sum;
    logic [9:0]         col_next;
    logic               fire_s1, fire_s2, fire_s3, fire_evt;
    state_t             state, state_next;
    logic [CDW-1:0]     cooldown, cd_next;
    logic               col_load;

    assign Player_Row = 9'(ROW_INIT);
    assign Shot_req   = (state == S_REQ);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            tick_cnt  <= '0;
            Move_tick <= 1'b0;
        end else begin
            Move_tick <= (tick_cnt == TICK_LAST);
            tick_cnt  <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + TW'(1);
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) joy_q <= '0;
        else          joy_q <= Joystick_data;
    end

    assign go_right = (joy_q > 4'd6);
    assign go_left  = (joy_q < 4'd4);

`ifdef PLAYER_ACCEL_EN
    // dir: 01 right, 10 left, 00 centre; step doubles once the updated hold count saturates
    logic [1:0] cur_dir, prev_dir;
    logic [2:0] hold_cnt, hold_next;

    assign cur_dir = {go_left, go_right};

    always_comb begin
        hold_next = '0;
        if (cur_dir != 2'b00 && cur_dir == prev_dir)
            hold_next = (hold_cnt == 3'd7) ? 3'd7 : hold_cnt + 3'd1;
        step_s = (hold_next == 3'd7) ? 11'(2 * STEP) : STEP_S;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            hold_cnt <= '0;
            prev_dir <= '0;
        end else if (Move_tick) begin
            hold_cnt <= hold_next;
            prev_dir <= cur_dir;
        end
    end
`else
    assign step_s = STEP_S;
`endif

    assign col_s = $signed({1'b0, Player_Col});

    always_comb begin
        col_sum = col_s;
        if (go_right) begin
            col_sum = col_s + step_s;
            if (col_sum > MAX_S) col_sum = MAX_S;
        end else if (go_left) begin
            col_sum = col_s - step_s;
            if (col_sum < MIN_S) col_sum = MIN_S;
        end
        col_next = col_sum[9:0];
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)       Player_Col <= 10'(COL_INIT);
        else if (Move_tick) Player_Col <= col_next;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            fire_s1  <= 1'b0;
            fire_s2  <= 1'b0;
            fire_s3  <= 1'b0;
            fire_evt <= 1'b0;
        end else begin
            fire_s1  <= Fire_btn;
            fire_s2  <= fire_s1;
            fire_s3  <= fire_s2;
            fire_evt <= fire_s2 & ~fire_s3;
        end
    end

    always_comb begin
        state_next = state;
        cd_next    = cooldown;
        col_load   = 1'b0;
        unique case (state)
            S_IDLE: if (fire_evt && !Shot_busy) begin
                state_next = S_REQ;
                col_load   = 1'b1;
            end
            S_REQ: if (Shot_ack) begin
                state_next = S_COOL;
                cd_next    = CD_LOAD;
            end
            S_COOL: if (Move_tick) begin
                cd_next = cooldown - CDW'(1);
                if (cooldown == CDW'(1)) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state    <= S_IDLE;
            cooldown <= '0;
            Shot_col <= '0;
        end else begin
            state    <= state_next;
            cooldown <= cd_next;
            if (col_load) Shot_col <= Player_Col;
        end
    end

endmodule
